// File: rtl/fila_movimentos.sv
// rtl/fila_movimentos.sv - move-code FIFO feeding the cube actuator over a start/done handshake
// Also requests the next host byte and flags the end of a move sequence.
module fila_movimentos #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          movimento_valido,
  input  logic [2:0]    movimento,
  input  logic          pronto_atuador,
  output logic          inicia_atuador,
  output logic [2:0]    movimento_atual,
  output logic          pede_proximo,
  output logic          fim_sequencia,
  output logic          ocupado,
  output logic          vazia,
  output logic          cheia,
  output logic [AW:0]   contagem,
  output logic          erro
);

  typedef enum logic [1:0] {OCIOSO, DESPACHA, AGUARDA, FINAL} estado_t;

  localparam logic [AW:0] CHEIO = (AW+1)'(DEPTH);

  estado_t       estado_q, estado_d;
  logic [2:0]    mem_q [DEPTH];
  logic [2:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cont_q, cont_d;
  logic [2:0]    mov_atual_q, mov_atual_d;
  logic          pede_q, pede_d;
  logic          erro_q, erro_d;
  logic          fim_rec_q, fim_rec_d;
  logic          pendente_q, pendente_d;

  logic eh_fim, eh_inv, eh_mov, push, pop, libera;

  assign eh_fim = movimento_valido && (movimento == 3'b000);
  assign eh_inv = movimento_valido && (movimento == 3'b111);
  assign eh_mov = movimento_valido && !eh_fim && !eh_inv;
  assign vazia  = (cont_q == '0);
  assign cheia  = (cont_q == CHEIO);
  assign push   = eh_mov && !cheia;
  assign pop    = (estado_q == OCIOSO) && !vazia;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mov_atual_d = mov_atual_q;
    cont_d      = cont_q + (AW+1)'(push) - (AW+1)'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = movimento;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      mov_atual_d = mem_q[rd_ptr_q];
      rd_ptr_d    = rd_ptr_q + AW'(1);
    end
    erro_d    = erro_q || eh_inv || (movimento_valido && cheia);
    fim_rec_d = (fim_rec_q && (estado_q != FINAL)) || eh_fim;
    // A request withheld because the FIFO filled up is released by the first pop.
    libera     = pendente_q && pop && (cont_d != CHEIO);
    pendente_d = (pendente_q && !libera) || (push && (cont_d == CHEIO));
    pede_d     = (push && (cont_d != CHEIO)) || (eh_inv && !cheia) || libera;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO: begin
        if (!vazia)         estado_d = DESPACHA;
        else if (fim_rec_q) estado_d = FINAL;
      end
      DESPACHA: estado_d = AGUARDA;
      AGUARDA:  if (pronto_atuador) estado_d = OCIOSO;
      FINAL:    estado_d = OCIOSO;
      default:  estado_d = OCIOSO;
    endcase
  end

  always_comb begin
    inicia_atuador  = (estado_q == DESPACHA);
    fim_sequencia   = (estado_q == FINAL);
    ocupado         = (estado_q != OCIOSO);
    movimento_atual = mov_atual_q;
    pede_proximo    = pede_q;
    contagem        = cont_q;
    erro            = erro_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= OCIOSO;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cont_q      <= '0;
      mov_atual_q <= '0;
      pede_q      <= 1'b0;
      erro_q      <= 1'b0;
      fim_rec_q   <= 1'b0;
      pendente_q  <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cont_q      <= cont_d;
      mov_atual_q <= mov_atual_d;
      pede_q      <= pede_d;
      erro_q      <= erro_d;
      fim_rec_q   <= fim_rec_d;
      pendente_q  <= pendente_d;
    end
  end

endmodule
